// File: rtl/tiny1_loader_pkg.sv
// tiny1_loader_pkg
// Shared definitions for the tiny1 serial boot loader: FSM state encoding,
// command byte values and default response/timeout constants.
package tiny1_loader_pkg;

    typedef enum logic [3:0] {
        StIdle,
        StHdr,
        StDataHi,
        StDataLo,
        StWrite,
        StAck,
        StNak,
        StRun,
        StRdReq,
        StRdWait,
        StTxHi,
        StTxLo
    } loader_state_e;

    localparam logic [7:0]  CMD_W                  = 8'h57;
    localparam logic [7:0]  CMD_G                  = 8'h47;
    localparam logic [7:0]  CMD_R                  = 8'h52;
    localparam logic [7:0]  ACK_BYTE_DEFAULT       = 8'h06;
    localparam logic [7:0]  NAK_BYTE_DEFAULT       = 8'h15;
    localparam logic [23:0] TIMEOUT_CYCLES_DEFAULT = 24'd12_000_000;

endpackage

// File: rtl/tiny1_loader_txq.sv
// tiny1_loader_txq
// Single-byte transmit holder in front of the buart transmitter. A byte is
// accepted on i_load when the holder is empty, then strobed out on the first
// cycle with i_uart_ready high. The cycle after a strobe is a blind gap: the
// transmitter's busy flag rises one cycle late, so ready is not trusted then.
// Ports:
//   i_clk, i_rst      clock, synchronous active-low reset
//   i_load, i_byte    request to send i_byte (level; accepted when empty)
//   i_uart_ready      transmitter idle
//   o_uart_wr         one-cycle transmit strobe (also tells the FSM "sent")
//   o_uart_out        held byte, valid with o_uart_wr
module tiny1_loader_txq (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_load,
    input  logic [7:0] i_byte,
    input  logic       i_uart_ready,
    output logic       o_uart_wr,
    output logic [7:0] o_uart_out
);

    logic       r_full;
    logic       r_gap;
    logic [7:0] r_data;
    logic       w_wr;

    assign w_wr       = r_full && !r_gap && i_uart_ready;
    assign o_uart_wr  = w_wr;
    assign o_uart_out = r_data;

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            r_full <= 1'b0;
            r_gap  <= 1'b0;
            r_data <= 8'h00;
        end else begin
            r_gap <= w_wr;
            if (w_wr) begin
                r_full <= 1'b0;
            end else if (i_load && !r_full && !r_gap) begin
                r_full <= 1'b1;
                r_data <= i_byte;
            end
        end
    end

endmodule

// File: rtl/tiny1_uart_loader.sv
// tiny1_uart_loader
// Serial boot loader: while the core is held in reset it takes commands from
// buart, writes 16-bit words into RAM and acknowledges each command. 'G'
// releases the core and hands UART/RAM over (o_active low).
// Optional feature macro: TINY1_LOADER_READBACK_EN enables the 'R' readback
// command; without it 'R' is NAKed, o_mem_re is 0 and i_mem_data_i is ignored.
// Ports:
//   i_clk, i_rst                  clock, synchronous active-low reset
//   i_uart_valid, i_uart_din      receive byte available / data
//   o_uart_rd                     one-cycle pulse consuming i_uart_din
//   i_uart_ready, o_uart_wr,
//   o_uart_out                    transmit handshake and byte
//   o_mem_addr, o_mem_data_o,
//   o_mem_wr, o_mem_re,
//   i_mem_data_i                  RAM port (byte address, word data)
//   o_core_rst_n, o_active        core reset and loader ownership
module tiny1_uart_loader
    import tiny1_loader_pkg::*;
#(
    parameter logic [7:0]  ACK_BYTE       = ACK_BYTE_DEFAULT,
    parameter logic [7:0]  NAK_BYTE       = NAK_BYTE_DEFAULT,
    parameter logic [23:0] TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_uart_valid,
    input  logic [7:0]  i_uart_din,
    output logic        o_uart_rd,
    input  logic        i_uart_ready,
    output logic        o_uart_wr,
    output logic [7:0]  o_uart_out,
    output logic [15:0] o_mem_addr,
    output logic [15:0] o_mem_data_o,
    output logic        o_mem_wr,
    output logic        o_mem_re,
    input  logic [15:0] i_mem_data_i,
    output logic        o_core_rst_n,
    output logic        o_active
);

    loader_state_e r_state, w_state_next;

    logic [7:0]  r_byte;
    logic        r_byte_vld;     // byte latched last cycle; also the intake gap
    logic [1:0]  r_hdr_idx;
    logic        r_is_go;
    logic [15:0] r_addr;
    logic [15:0] r_len;
    logic [15:0] r_word;
    logic [23:0] r_tmo_cnt;

    logic        w_intake;
    logic        w_take;
    logic        w_tmo_run;
    logic        w_timeout;
    logic        w_tx_load;
    logic [7:0]  w_tx_byte;
    logic        w_tx_done;

`ifdef TINY1_LOADER_READBACK_EN
    logic        r_is_read;
`else
    logic        w_unused_mem;
    assign w_unused_mem = ^i_mem_data_i;
`endif

    assign w_intake  = (r_state == StIdle) || (r_state == StHdr) ||
                       (r_state == StDataHi) || (r_state == StDataLo);
    assign w_take    = w_intake && i_uart_valid && !r_byte_vld;
    assign w_tmo_run = (r_state == StHdr) || (r_state == StDataHi) || (r_state == StDataLo);
    // A byte arriving in the expiry cycle cancels the timeout.
    assign w_timeout = w_tmo_run && !w_take && !r_byte_vld &&
                       (r_tmo_cnt == TIMEOUT_CYCLES - 24'd1);

    // State register
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            StIdle: begin
                if (r_byte_vld) begin
                    if (r_byte == CMD_W) begin
                        w_state_next = StHdr;
                    end else if (r_byte == CMD_G) begin
                        w_state_next = StAck;
`ifdef TINY1_LOADER_READBACK_EN
                    end else if (r_byte == CMD_R) begin
                        w_state_next = StHdr;
`endif
                    end else begin
                        w_state_next = StNak;
                    end
                end
            end
            StHdr: begin
                if (w_timeout) begin
                    w_state_next = StIdle;
                end else if (r_byte_vld && (r_hdr_idx == 2'd3)) begin
                    if ({r_len[15:8], r_byte} == 16'd0) begin
                        w_state_next = StAck;
`ifdef TINY1_LOADER_READBACK_EN
                    end else if (r_is_read) begin
                        w_state_next = StRdReq;
`endif
                    end else begin
                        w_state_next = StDataHi;
                    end
                end
            end
            StDataHi: begin
                if (w_timeout) w_state_next = StIdle;
                else if (r_byte_vld) w_state_next = StDataLo;
            end
            StDataLo: begin
                if (w_timeout) w_state_next = StIdle;
                else if (r_byte_vld) w_state_next = StWrite;
            end
            StWrite: w_state_next = (r_len == 16'd1) ? StAck : StDataHi;
            StAck: begin
                if (w_tx_done) w_state_next = r_is_go ? StRun : StIdle;
            end
            StNak: begin
                if (w_tx_done) w_state_next = StIdle;
            end
            StRun: w_state_next = StRun;
`ifdef TINY1_LOADER_READBACK_EN
            StRdReq:  w_state_next = StRdWait;
            StRdWait: w_state_next = StTxHi;
            StTxHi: begin
                if (w_tx_done) w_state_next = StTxLo;
            end
            StTxLo: begin
                if (w_tx_done) w_state_next = (r_len == 16'd1) ? StAck : StRdReq;
            end
`endif
            default: w_state_next = StIdle;
        endcase
    end

    // Byte intake, header/data capture, address/length stepping, timeout
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            r_byte     <= 8'h00;
            r_byte_vld <= 1'b0;
            r_hdr_idx  <= 2'd0;
            r_is_go    <= 1'b0;
            r_addr     <= 16'h0000;
            r_len      <= 16'h0000;
            r_word     <= 16'h0000;
            r_tmo_cnt  <= 24'd0;
`ifdef TINY1_LOADER_READBACK_EN
            r_is_read  <= 1'b0;
`endif
        end else begin
            r_byte_vld <= w_take;
            if (w_take) r_byte <= i_uart_din;
            if (w_take || !w_tmo_run) r_tmo_cnt <= 24'd0;
            else                      r_tmo_cnt <= r_tmo_cnt + 24'd1;

            case (r_state)
                StIdle: begin
                    if (r_byte_vld) begin
                        r_hdr_idx <= 2'd0;
                        r_is_go   <= (r_byte == CMD_G);
`ifdef TINY1_LOADER_READBACK_EN
                        r_is_read <= (r_byte == CMD_R);
`endif
                    end
                end
                StHdr: begin
                    if (r_byte_vld) begin
                        r_hdr_idx <= r_hdr_idx + 2'd1;
                        case (r_hdr_idx)
                            2'd0:    r_addr[15:8] <= r_byte;
                            2'd1:    r_addr[7:0]  <= {r_byte[7:1], 1'b0};
                            2'd2:    r_len[15:8]  <= r_byte;
                            default: r_len[7:0]   <= r_byte;
                        endcase
                    end
                end
                StDataHi: if (r_byte_vld) r_word[15:8] <= r_byte;
                StDataLo: if (r_byte_vld) r_word[7:0]  <= r_byte;
                StWrite: begin
                    r_addr <= r_addr + 16'd2;   // 0xFFFE wraps to 0x0000
                    r_len  <= r_len - 16'd1;
                end
`ifdef TINY1_LOADER_READBACK_EN
                StRdWait: r_word <= i_mem_data_i;
                StTxLo: begin
                    if (w_tx_done) begin
                        r_addr <= r_addr + 16'd2;
                        r_len  <= r_len - 16'd1;
                    end
                end
`endif
                default: ;
            endcase
        end
    end

    // Outputs
    always_comb begin
        o_mem_wr     = 1'b0;
        o_mem_re     = 1'b0;
        o_core_rst_n = 1'b0;
        w_tx_load    = 1'b0;
        w_tx_byte    = 8'h00;
        case (r_state)
            StWrite: o_mem_wr = 1'b1;
            StAck: begin
                w_tx_load = 1'b1;
                w_tx_byte = ACK_BYTE;
            end
            StNak: begin
                w_tx_load = 1'b1;
                w_tx_byte = NAK_BYTE;
            end
            StRun: o_core_rst_n = 1'b1;
`ifdef TINY1_LOADER_READBACK_EN
            StRdReq: o_mem_re = 1'b1;
            StTxHi: begin
                w_tx_load = 1'b1;
                w_tx_byte = r_word[15:8];
            end
            StTxLo: begin
                w_tx_load = 1'b1;
                w_tx_byte = r_word[7:0];
            end
`endif
            default: ;
        endcase
    end

    assign o_uart_rd    = w_take;
    assign o_active     = !o_core_rst_n;
    assign o_mem_addr   = r_addr;
    assign o_mem_data_o = r_word;
    assign o_uart_wr    = w_tx_done;

    tiny1_loader_txq u_txq (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
        .i_load       (w_tx_load),
        .i_byte       (w_tx_byte),
        .i_uart_ready (i_uart_ready),
        .o_uart_wr    (w_tx_done),
        .o_uart_out   (o_uart_out)
    );

endmodule
